hyst_track: RTL and testbench



---
 rtl/hyst_track_if.sv | 11 +
 rtl/hyst_track.sv | 202 ++++++++++++++++++++
 tb/tb_hyst_track.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyst_track_if.sv
// Pixel stream handshake shared by the classified input and the edge-map output.
`timescale 1ns/1ps
interface hyst_track_if;
  logic [7:0] dout;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output dout, valid, last, input ready);
  modport slave  (input dout, valid, last, output ready);
endinterface

// File: rtl/hyst_track.sv
// Hysteresis edge tracking: promotes weak pixels touching a strong neighbour.
// Output stream runs one row behind the input; the last row is flushed at frame end.
`timescale 1ns/1ps
module hyst_track #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 4100
) (
  input  logic         clk,
  input  logic         rst_n,
  hyst_track_if.slave  dualth_axi,
  hyst_track_if.master hyst_axi,
  output logic         hyst_err
);

  // state | meaning
  // FILL  | input row 0 into line buffers, no output
  // RUN   | input rows 1..H-1, emit row r-1 one column behind
  // DRAIN | emit last column of row r-1, input stalled
  // FLUSH | emit row H-1 against a zero bottom row, input stalled

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [1:0] CLS_STRONG = 2'b10;
  localparam logic [1:0] CLS_WEAK   = 2'b01;

  typedef enum logic [1:0] {S_FILL, S_RUN, S_DRAIN, S_FLUSH} state_t;
  state_t state, state_nxt;

  logic [COL_W-1:0] col, fcol, fcol_inc;
  logic [ROW_W-1:0] row;
  logic [1:0] lb0 [IMG_W];
  logic [1:0] lb1 [IMG_W];
  // win[row][col]: row 0 top .. 2 bottom, col 0 left .. 2 right
  logic [2:0][2:0][1:0] win, win_nxt;
  logic [2:0][1:0]      new_col;
  logic [1:0] in_cls;

  logic in_ready, accept, slot_free;
  logic out_load, load_last, win_shift;
  logic edge_pix, nb_strong;
  logic [7:0] out_dout;
  logic out_valid, out_last;

  assign slot_free = !out_valid || hyst_axi.ready;
  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign dualth_axi.ready = in_ready && rst_n;
  assign accept    = dualth_axi.valid && dualth_axi.ready;
  assign fcol_inc  = fcol + 1'b1;

  always_comb begin
    in_cls = CLS_WEAK;
    if (dualth_axi.dout == 8'hFF)      in_cls = CLS_STRONG;
    else if (dualth_axi.dout == 8'h00) in_cls = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (accept && col == COL_LAST) state_nxt = S_RUN;
      S_RUN:   if (accept && col == COL_LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (slot_free) state_nxt = (row == '0) ? S_FLUSH : S_RUN;
      S_FLUSH: if (slot_free && fcol == COL_LAST) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_load  = 1'b0;
    load_last = 1'b0;
    win_shift = 1'b0;
    case (state)
      S_FILL: in_ready = 1'b1;
      S_RUN: begin
        in_ready  = slot_free;
        win_shift = dualth_axi.valid && slot_free;
        out_load  = dualth_axi.valid && slot_free && (col != '0);
      end
      S_DRAIN: begin
        out_load  = slot_free;
        load_last = 1'b1;
        win_shift = slot_free;
      end
      S_FLUSH: begin
        out_load  = slot_free;
        load_last = (fcol == COL_LAST);
        win_shift = slot_free;
      end
      default: ;
    endcase
  end

  // Column entering the window; anything outside the image stays zero.
  always_comb begin
    new_col = '0;
    case (state)
      S_RUN: begin
        new_col[0] = (row == ROW_W'(1)) ? 2'b00 : lb1[col];
        new_col[1] = lb0[col];
        new_col[2] = in_cls;
      end
      S_FLUSH: begin
        if (fcol != COL_LAST) begin
          new_col[0] = lb1[fcol_inc];
          new_col[1] = lb0[fcol_inc];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    win_nxt = win;
    if (win_shift) begin
      for (int r = 0; r < 3; r++) begin
        win_nxt[r][0] = (state == S_RUN && col == '0) ? 2'b00 : win[r][1];
        win_nxt[r][1] = (state == S_RUN && col == '0) ? 2'b00 : win[r][2];
        win_nxt[r][2] = new_col[r];
      end
    end
  end

  always_comb begin
    nb_strong = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((r != 1 || c != 1) && win_nxt[r][c] == CLS_STRONG) nb_strong = 1'b1;
      end
    end
    edge_pix = (win_nxt[1][1] == CLS_STRONG) ||
               (win_nxt[1][1] == CLS_WEAK && nb_strong);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= in_cls;
      lb1[col] <= lb0[col];
    end
  end

  // DRAIN primes the window with column 0 of the just-finished row so FLUSH
  // can emit one beat per cycle; a following RUN row overwrites it anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (state == S_DRAIN && slot_free) begin
      win       <= '0;
      win[0][2] <= lb1[0];
      win[1][2] <= lb0[0];
    end else begin
      win <= win_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      hyst_err <= 1'b0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (dualth_axi.last != (col == COL_LAST)) hyst_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          fcol <= '0;
    else if (state == S_FLUSH && slot_free) fcol <= (fcol == COL_LAST) ? '0 : fcol_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_dout  <= 8'h00;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_last  <= load_last;
      out_dout  <= edge_pix ? 8'hFF : 8'h00;
    end else if (hyst_axi.ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign hyst_axi.valid = out_valid;
  assign hyst_axi.last  = out_last;
  assign hyst_axi.dout  = out_dout;

endmodule

// File: tb/tb_hyst_track.sv
// Directed bench for hyst_track on a 4x3 image: edge maps, backpressure, last errors, reset.
`timescale 1ns/1ps
module tb_hyst_track;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n;
  logic hyst_err;

  hyst_track_if in_if ();
  hyst_track_if out_if ();

  hyst_track #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dualth_axi (in_if),
    .hyst_axi   (out_if),
    .hyst_err   (hyst_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ocnt     = 0;
  int low_cnt  = 0;
  bit cnt_en   = 1'b0;
  bit rnd_rdy  = 1'b0;
  logic rdy_val = 1'b1;
  bit prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic prev_l;
  logic [7:0] cap_d [64];
  logic       cap_l [64];

  logic [7:0] f_all [N];
  logic [7:0] f_t2a [N];
  logic [7:0] f_t2b [N];
  logic [7:0] f_t3  [N];
  logic [7:0] f_ra  [N];
  logic [7:0] f_rb  [N];
  logic [7:0] e     [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_if.ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_if.valid, 1);
        check("stall_dout", out_if.dout, prev_d);
        check("stall_last", out_if.last, prev_l);
      end
      if (out_if.valid && out_if.ready) begin
        if (ocnt < 64) begin
          cap_d[ocnt] = out_if.dout;
          cap_l[ocnt] = out_if.last;
        end
        ocnt++;
      end
      if (cnt_en && !in_if.ready) low_cnt++;
      prev_stall = out_if.valid && !out_if.ready;
      prev_d = out_if.dout;
      prev_l = out_if.last;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input bit gaps);
    int g;
    int guard;
    if (gaps) begin
      g = $urandom_range(0, 2);
      in_if.valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    in_if.dout  = d;
    in_if.last  = l;
    in_if.valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_if.ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        n_assert++;
        n_fail++;
        $display("FAIL accept_timeout: beat %0h not accepted within %0d cycles", d, guard);
        break;
      end
    end
    in_if.valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] img [N], input logic [N-1:0] lmask, input bit gaps);
    for (int i = 0; i < N; i++) send_beat(img[i], lmask[i], gaps);
  endtask

  task automatic wait_out(input int n);
    int guard;
    guard = 0;
    while (ocnt < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("out_count", ocnt, n);
    @(posedge clk);
    #1;
  endtask

  task automatic check_map(input string tag, input int base, input logic [7:0] exp [N]);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_dout%0d", tag, i), cap_d[base + i], exp[i]);
      check($sformatf("%s_last%0d", tag, i), cap_l[base + i], (i % W) == W - 1);
    end
  endtask

  function automatic logic [7:0] ref_pix(input logic [7:0] img [N], input int r, input int c);
    bit nb;
    logic [7:0] p;
    nb = 1'b0;
    p  = img[r * W + c];
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
          if (img[(r + dr) * W + c + dc] == 8'hFF) nb = 1'b1;
      end
    end
    if (p == 8'hFF) return 8'hFF;
    if (p != 8'h00 && nb) return 8'hFF;
    return 8'h00;
  endfunction

  initial begin
    f_all = '{default: 8'hFF};
    f_t2a = '{default: 8'h00};
    f_t2a[0] = 8'hFF;
    f_t2a[5] = 8'h40;
    f_t2b = '{default: 8'h00};
    f_t2b[3] = 8'hFF;
    f_t2b[5] = 8'h40;
    f_t3 = '{default: 8'h00};
    f_t3[0] = 8'h40;
    f_t3[1] = 8'h40;
    f_t3[2] = 8'hFF;
    f_ra = '{8'hFF, 8'h00, 8'h40, 8'h00,
             8'h00, 8'h80, 8'h00, 8'h01,
             8'h10, 8'h00, 8'h00, 8'hFF};
    f_rb = '{8'h20, 8'h20, 8'h20, 8'hFF,
             8'h00, 8'hFF, 8'h00, 8'h30,
             8'h55, 8'h00, 8'h33, 8'h00};

    rst_n = 1'b0;
    in_if.valid = 1'b0;
    in_if.dout  = 8'h00;
    in_if.last  = 1'b0;
    #12;
    check("rst_ready", in_if.ready, 0);
    check("rst_valid", out_if.valid, 0);
    check("rst_last", out_if.last, 0);
    check("rst_dout", out_if.dout, 8'h00);
    check("rst_err", hyst_err, 0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", in_if.ready, 1);
    @(posedge clk);
    #1;

    // all strong, ready held high
    ocnt = 0;
    low_cnt = 0;
    cnt_en = 1'b1;
    send_frame(f_all, 12'h888, 1'b0);
    wait_out(N);
    cnt_en = 1'b0;
    check("t1_ready_low_cycles", low_cnt, 6);
    e = '{default: 8'hFF};
    check_map("t1", 0, e);

    // weak at (1,1) next to strong at (0,0)
    ocnt = 0;
    send_frame(f_t2a, 12'h888, 1'b0);
    wait_out(N);
    e = '{default: 8'h00};
    e[0] = 8'hFF;
    e[5] = 8'hFF;
    check_map("t2a", 0, e);

    // strong moved out of reach to (0,3)
    ocnt = 0;
    send_frame(f_t2b, 12'h888, 1'b0);
    wait_out(N);
    e = '{default: 8'h00};
    e[3] = 8'hFF;
    check_map("t2b", 0, e);

    // weak-weak-strong chain: only one hop of promotion
    ocnt = 0;
    send_frame(f_t3, 12'h888, 1'b0);
    wait_out(N);
    e = '{default: 8'h00};
    e[1] = 8'hFF;
    e[2] = 8'hFF;
    check_map("t3", 0, e);
    check("t3_err_clear", hyst_err, 0);

    // two frames back-to-back with random gaps and random downstream ready
    ocnt = 0;
    rnd_rdy = 1'b1;
    send_frame(f_ra, 12'h888, 1'b1);
    send_frame(f_rb, 12'h888, 1'b1);
    wait_out(2 * N);
    rnd_rdy = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) e[r * W + c] = ref_pix(f_ra, r, c);
    check_map("t4a", 0, e);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) e[r * W + c] = ref_pix(f_rb, r, c);
    check_map("t4b", N, e);

    // last at column 2 instead of 3 in row 0
    ocnt = 0;
    send_frame(f_all, 12'h884, 1'b0);
    wait_out(N);
    check("t5_err", hyst_err, 1);
    e = '{default: 8'hFF};
    check_map("t5", 0, e);

    // reset in the middle of row 1 with an output beat pending
    rdy_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ocnt = 0;
    for (int i = 0; i < W + 2; i++) send_beat(f_all[i], i == W - 1, 1'b0);
    check("t6_err_sticky", hyst_err, 1);
    check("t6_pre_valid", out_if.valid, 1);
    check("t6_pre_dout", out_if.dout, 8'hFF);
    check("t6_pre_ready", in_if.ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", in_if.ready, 0);
    check("t6_rst_valid", out_if.valid, 0);
    check("t6_rst_last", out_if.last, 0);
    check("t6_rst_dout", out_if.dout, 8'h00);
    check("t6_rst_err", hyst_err, 0);
    repeat (2) @(posedge clk);
    rdy_val = 1'b1;
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("t6_rel_ready", in_if.ready, 1);
    check("t6_none_out", ocnt, 0);
    @(posedge clk);
    #2;
    ocnt = 0;
    send_frame(f_t2a, 12'h888, 1'b0);
    wait_out(N);
    e = '{default: 8'h00};
    e[0] = 8'hFF;
    e[5] = 8'hFF;
    check_map("t6", 0, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
